// File: rtl/matmul_pkg.sv
// Shared types and sizes for the 2x2 matrix-multiply sequencer.
package matmul_pkg;

    localparam int EW     = 4;               // operand element width
    localparam int RW     = 9;               // result width, holds 2*15*15 = 450
    localparam int N_ELEM = 4;               // elements per 2x2 matrix
    localparam int IW     = $clog2(N_ELEM);  // element index width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC0,
        MAC1,
        CAPT,
        OUT
    } state_t;

endpackage

// File: rtl/matmul_operand_regs.sv
// Four packed {A,B} operand slots: one write port, independent A and B reads.
module matmul_operand_regs
    import matmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [2*EW-1:0] wdata,
    input  logic [IW-1:0]   raddr_a,
    input  logic [IW-1:0]   raddr_b,
    output logic [EW-1:0]   rd_a,
    output logic [EW-1:0]   rd_b
);

    logic [N_ELEM-1:0][2*EW-1:0] slot;

    // Slot storage, cleared by reset, written one beat at a time.
    always_ff @(posedge clk) begin
        if (rst)
            slot <= '0;
        else if (we)
            slot[waddr] <= wdata;
    end

    // A lives in the upper nibble, B in the lower nibble of each slot.
    assign rd_a = slot[raddr_a][2*EW-1:EW];
    assign rd_b = slot[raddr_b][EW-1:0];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for a 2x2 multiply on an external MAC: load 4 beats, then per
// result element run clear-MAC, accumulate-MAC, capture, and output.
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    output logic [EW-1:0] mac_a,
    output logic [EW-1:0] mac_b,
    output logic          mac_clr,
    output logic          mac_en,
    input  logic [RW-1:0] mac_acc,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic [IW-1:0] res_idx,
    output logic          busy,
    output logic          done
);

    state_t        state, state_d;
    logic [IW-1:0] k, n;
    logic [RW-1:0] res_q;
    logic [IW-1:0] raddr_a, raddr_b;
    logic [EW-1:0] rd_a, rd_b;
    logic          load_fire, out_fire;

    // Handshakes only complete while enabled and in their owning state.
    assign load_fire = ena && (state == LOAD) && load_valid;
    assign out_fire  = ena && (state == OUT) && res_ready;

    matmul_operand_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (load_fire),
        .waddr   (k),
        .wdata   (load_data),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // State, beat/element counters and the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            n     <= '0;
            res_q <= '0;
        end else begin
            state <= state_d;
            if (ena && state == IDLE && start) begin
                k <= '0;
                n <= '0;
            end
            if (load_fire)
                k <= k + 2'd1;
            if (ena && state == CAPT)
                res_q <= mac_acc;
            if (out_fire)
                n <= n + 2'd1;
        end
    end

    // Next-state selection; ena low freezes the FSM.
    always_comb begin
        state_d = state;
        if (ena) begin
            unique case (state)
                IDLE:    if (start) state_d = LOAD;
                LOAD:    if (load_valid && k == 2'd3) state_d = MAC0;
                MAC0:    state_d = MAC1;
                MAC1:    state_d = CAPT;
                CAPT:    state_d = OUT;
                OUT:     if (res_ready) state_d = (n == 2'd3) ? IDLE : MAC0;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand selection and MAC control; n = 2i+j picks row i, column j.
    always_comb begin
        raddr_a = '0;
        raddr_b = '0;
        mac_a   = '0;
        mac_b   = '0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        if (state == MAC0) begin
            raddr_a = {n[1], 1'b0};
            raddr_b = {1'b0, n[0]};
            mac_a   = rd_a;
            mac_b   = rd_b;
            mac_en  = ena;
            mac_clr = ena;
        end else if (state == MAC1) begin
            raddr_a = {n[1], 1'b1};
            raddr_b = {1'b1, n[0]};
            mac_a   = rd_a;
            mac_b   = rd_b;
            mac_en  = ena;
        end
    end

    assign load_ready = ena && (state == LOAD);
    assign res_valid  = (state == OUT);
    assign res_data   = res_q;
    assign res_idx    = n;
    assign busy       = (state != IDLE);
    assign done       = out_fire && (n == 2'd3);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: MAC model, directed runs, scoreboard monitor.
module tb_matmul_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1, ena = 1'b1, start = 1'b0, load_valid = 1'b0, res_ready = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready, mac_clr, mac_en, res_valid, busy, done;
    logic [3:0] mac_a, mac_b;
    logic [8:0] mac_acc, res_data;
    logic [1:0] res_idx;

    matmul_seq_ctrl dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // External MAC: registered accumulator, one cycle latency.
    always @(posedge clk) begin
        if (rst) mac_acc <= '0;
        else if (mac_en)
            mac_acc <= mac_clr ? ({5'd0, mac_a} * {5'd0, mac_b})
                               : mac_acc + ({5'd0, mac_a} * {5'd0, mac_b});
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] idx; logic [8:0] data; } exp_t;
    exp_t q[$];
    int   total = 0, bad = 0, done_cnt = 0, last_acc = -1;
    bit   check_tp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops on each accepted result, checks hold stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_done;
        exp_done = 0;
        if (!rst && ena && res_valid && res_ready) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e = q.pop_front();
                chk("res_idx", res_idx, e.idx);
                chk("res_data", res_data, e.data);
                exp_done = (e.idx == 2'd3);
                if (check_tp && e.idx != 0 && last_acc >= 0)
                    chk("throughput", cyc - last_acc, 4);
                last_acc = cyc;
            end
        end else if (!rst && res_valid && q.size() > 0) begin
            chk("hold_data", res_data, q[0].data);
            chk("hold_idx", res_idx, q[0].idx);
        end
        if (done || exp_done) chk("done_pulse", done, exp_done);
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic push4(input int d0, input int d1, input int d2, input int d3);
        exp_t e;
        int   d[4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            e.idx = 2'(i); e.data = 9'(d[i]); q.push_back(e);
        end
    endtask

    // Start a run and stream four beats; returns just after beat 3 is accepted.
    task automatic load(input logic [31:0] beats);
        start = 1; tick; start = 0;
        chk("load_ready_in_load", load_ready, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = beats[31-8*i -: 8]; tick;
        end
        load_valid = 0;
    endtask

    // Consume everything queued; stall>0 holds res_ready low that many cycles per result.
    task automatic drain(input int stall);
        int guard = 0;
        if (stall == 0) begin
            res_ready = 1;
            while (q.size() > 0 && guard < 60) begin tick; guard++; end
            res_ready = 0;
        end else begin
            while (q.size() > 0 && guard < 300) begin
                while (!res_valid && guard < 300) begin tick; guard++; end
                repeat (stall) begin tick; guard++; end
                res_ready = 1; tick; res_ready = 0; guard++;
            end
        end
        chk("drain_in_time", guard < ((stall == 0) ? 60 : 300), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, g;
        // Reset state
        tick; tick;
        chk("rst_busy", busy, 0);       chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0); chk("rst_res_idx", res_idx, 0);
        chk("rst_load_ready", load_ready, 0); chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0); chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);     chk("rst_done", done, 0);
        rst = 0; tick;
        chk("idle_load_ready", load_ready, 0);

        // Basic run: first result in the 4th cycle after the beat-3 edge, then one per 4 cycles
        push4(19, 22, 43, 50);
        last_acc = -1; check_tp = 1; res_ready = 1;
        load(32'h15263748);
        lat = 0;
        while (!res_valid && lat < 20) begin tick; lat++; end
        chk("first_result_latency_edges", lat, 3);
        drain(0);
        check_tp = 0;

        // Maximum operands: 2*15*15 = 450, no wrap
        push4(450, 450, 450, 450);
        load(32'hFFFFFFFF);
        drain(0);

        // Identity A, B = [9,3,0,15], consumer stalls 5 cycles on each result
        push4(9, 3, 0, 15);
        load(32'h1903001F);
        drain(5);

        // Enable dropped for 3 cycles during MAC1 of element 0
        push4(19, 22, 43, 50);
        load(32'h15263748);
        chk("mac0_clr", mac_clr, 1); chk("mac0_a", mac_a, 1); chk("mac0_b", mac_b, 5);
        tick;
        chk("mac1_en", mac_en, 1); chk("mac1_clr", mac_clr, 0);
        chk("mac1_a", mac_a, 2);   chk("mac1_b", mac_b, 7);
        ena = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("ena0_mac_en", mac_en, 0); chk("ena0_mac_clr", mac_clr, 0);
            chk("ena0_busy", busy, 1);
        end
        ena = 1;
        drain(0);

        // Reset while presenting element 2
        push4(19, 22, 0, 0);
        void'(q.pop_back()); void'(q.pop_back());
        load(32'h15263748);
        res_ready = 1; g = 0;
        while (q.size() > 0 && g < 60) begin tick; g++; end
        res_ready = 0;
        while (!res_valid && g < 80) begin tick; g++; end
        chk("pre_rst_idx", res_idx, 2);
        rst = 1; tick; rst = 0;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_idx", res_idx, 0); chk("mid_rst_res_data", res_data, 0);
        push4(19, 22, 43, 50);
        load(32'h15263748);
        drain(0);

        // start and load_valid pulsed while in OUT are ignored
        push4(19, 22, 43, 50);
        load(32'h15263748);
        g = 0;
        while (!res_valid && g < 20) begin tick; g++; end
        start = 1; load_valid = 1; load_data = 8'hEE; tick;
        start = 0; load_valid = 0;
        chk("ign_load_ready", load_ready, 0); chk("ign_res_valid", res_valid, 1);
        chk("ign_res_idx", res_idx, 0);       chk("ign_busy", busy, 1);
        drain(3);
        tick;
        chk("end_busy", busy, 0);
        chk("done_count", done_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
